fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end for the pipelined processor: it owns the PC register, issues instruction-memory reads through the datapath–cache interface signals, and buffers fetched instructions with their PC+4 in a DEPTH-entry FIFO. The FIFO feeds the IF/ID latch. The block decouples fetch from decode stalls, flushes on control-flow redirects from later stages, and stops fetching on halt.

## Interface
- PC_INIT, 0, PC value loaded at reset
- DEPTH, 4, FIFO entries; power of two, at least 2
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction cache returned `imemload` for `imemaddr` this cycle
- imemload  in  32  fetched instruction word
- imemREN  out  1  instruction read request
- imemaddr  out  32  fetch address; equals the PC register
- redirect  in  1  a later stage changes control flow; flush and reload the PC
- redirect_pc  in  32  new PC when `redirect` is high
- halt  in  1  stop issuing fetches; sticky until reset
- deq_ready  in  1  IF/ID accepts the head entry this cycle
- deq_valid  out  1  head entry is valid
- deq_instr  out  32  head instruction
- deq_pc4  out  32  PC+4 of the head instruction
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- State:
  - PC register
  - sticky `halted` flag
  - FIFO storage: DEPTH × {instr, pc4}
  - head and tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH
  - occupancy counter
- `imemREN` = !halted && !redirect && (count < DEPTH). The request is combinational.
- Enqueue condition: `imemREN && ihit`.
  - Write {imemload, PC+4} at the tail.
  - Advance the tail.
  - Set PC to PC+4, using 32-bit wrap-around arithmetic (0xFFFFFFFC → 0x00000000).
- Dequeue condition: `deq_valid && deq_ready`. Advance the head.
- `deq_valid` = (count != 0).
- `deq_instr` and `deq_pc4` show the head entry when valid, and are forced to 0 when not valid.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Full (count == DEPTH):
  - `imemREN` is low, so `ihit` is ignored.
  - A dequeue in that cycle re-enables `imemREN` on the next cycle.
- Empty: `deq_valid` is low and `deq_ready` has no effect.
- `redirect` has the highest priority.
  - Head, tail and count go to 0.
  - PC is set to `redirect_pc`.
  - Any `ihit` in the same cycle is discarded.
  - Any `deq_ready` in the same cycle is ignored.
- `halt` sets `halted` on the edge.
  - Once halted, `imemREN` stays 0 and the PC freezes.
  - The FIFO keeps draining.
  - A later `redirect` still flushes the FIFO and loads the PC, but fetching does not resume.
- Reset takes effect mid-operation asynchronously. All in-flight entries are lost.

## Timing
- Values while `nRST` is low:
  - PC = PC_INIT
  - count = 0, pointers = 0, halted = 0
  - `deq_valid` = 0, `deq_instr` = 0, `deq_pc4` = 0
  - `imemaddr` = PC_INIT
  - `imemREN` = 1 (when `redirect` and `halt` are idle)
- Fetch latency: `ihit` on cycle N → entry visible with `deq_valid`=1 on cycle N+1.
- Throughput: one enqueue and one dequeue per cycle.
- Redirect latency: `redirect` on cycle N → `imemaddr` = `redirect_pc` and `imemREN`=1 on cycle N+1.
- `count`, `deq_*` and `imemaddr` are driven from registers only.
- `imemREN` is the only output that depends combinationally on inputs (`redirect`).

## Configuration
- Macro `FETCH_QUEUE_BYPASS_EN`.
- Defined: when count == 0 and an enqueue occurs, that cycle drives:
  - `deq_valid`=1
  - `deq_instr`=`imemload`
  - `deq_pc4`=PC+4

  If `deq_ready` is also high, the word is consumed and not written, and count stays 0. If `deq_ready` is low, the word is enqueued normally.
- Bypass gives zero-cycle fetch-to-decode latency when the FIFO is empty. It adds a combinational path from `ihit`/`imemload` to `deq_*`.
- Undefined: no bypass, and the Timing latencies above apply exactly.

## Test plan
- Reset, then `ihit`=1 every cycle with `imemload`=0x20010001, 0x20020002, … and `deq_ready`=1:
  - `imemaddr` sequence is 0, 4, 8.
  - `deq_instr` presents the words in order, one cycle after each hit.
  - `deq_pc4` sequence is 4, 8, 12.
- `deq_ready`=0 with continuous `ihit`:
  - count rises to 4 (DEPTH=4) and `imemREN` drops.
  - PC holds at 0x10.
  - Raising `deq_ready` for one cycle pops the entry with `deq_pc4`=4 and re-enables `imemREN` on the next cycle.
- Two-entry FIFO, then `redirect`=1 with `redirect_pc`=0x40, `ihit`=1 and `deq_ready`=1 in the same cycle:
  - Next cycle: count=0, `deq_valid`=0, `imemaddr`=0x40.
  - The concurrent hit is not enqueued.
- `halt` pulse with 3 entries queued:
  - `imemREN` is 0 from the next cycle onward.
  - The 3 entries drain with `deq_ready`=1.
  - `redirect` to 0x80 afterwards gives `imemaddr`=0x80 and `imemREN` stays 0.
- Drive `nRST` low mid-stream with count=2 and PC=0x1C:
  - Immediately: count=0, `deq_valid`=0, `imemaddr`=PC_INIT (0).
- With `FETCH_QUEUE_BYPASS_EN`, empty FIFO, `ihit`=1, `imemload`=0x8C030000, `deq_ready`=1:
  - Same cycle: `deq_valid`=1, `deq_instr`=0x8C030000.
  - Next cycle: count=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, I-cache read request and a DEPTH-entry {instr, pc4} FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         ihit,
    input  logic [31:0]                  imemload,
    output logic                         imemREN,
    output logic [31:0]                  imemaddr,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    input  logic                         halt,
    input  logic                         deq_ready,
    output logic                         deq_valid,
    output logic [31:0]                  deq_instr,
    output logic [31:0]                  deq_pc4,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic          halted_q, halted_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc4_mem_q   [DEPTH];

    logic [31:0] pc_plus4;
    logic        fifo_valid, full, enq, wr, pop;
    logic [31:0] fifo_instr, fifo_pc4;

    assign pc_plus4   = pc_q + 32'd4;
    assign fifo_valid = (count_q != '0);
    assign full       = (count_q == CW'(DEPTH));
    assign imemREN    = !halted_q && !redirect && !full;
    assign enq        = imemREN && ihit;
    assign pop        = fifo_valid && deq_ready;
    assign fifo_instr = fifo_valid ? instr_mem_q[head_q] : '0;
    assign fifo_pc4   = fifo_valid ? pc4_mem_q[head_q]   : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // A word arriving at an empty FIFO is shown directly; it is stored only if not taken.
    assign bypass    = enq && !fifo_valid;
    assign wr        = enq && !(bypass && deq_ready);
    assign deq_valid = fifo_valid || bypass;
    assign deq_instr = bypass ? imemload : fifo_instr;
    assign deq_pc4   = bypass ? pc_plus4 : fifo_pc4;
`else
    assign wr        = enq;
    assign deq_valid = fifo_valid;
    assign deq_instr = fifo_instr;
    assign deq_pc4   = fifo_pc4;
`endif

    assign imemaddr = pc_q;
    assign count    = count_q;

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q | halt;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) pc_d = pc_plus4;
            if (wr)  tail_d = tail_q + PW'(1);
            if (pop) head_d = head_q + PW'(1);
            count_d = count_q + CW'(wr) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q     <= PC_INIT;
            halted_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: unoccupied slots are never presented.
    always_ff @(posedge CLK) begin
        if (wr) begin
            instr_mem_q[tail_q] <= imemload;
            pc4_mem_q[tail_q]   <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: hand-written vector table plus a queue-based reference model.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        deq_ready = 1'b0;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc4;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.PC_INIT(32'h0), .DEPTH(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .deq_ready(deq_ready),
        .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc4(deq_pc4),
        .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_halt;

    typedef struct {
        logic        rst;
        logic        ih;
        logic [31:0] ld;
        logic        dr;
        logic [31:0] addr;
        logic        ren;
        logic [2:0]  cnt;
        logic        v;
        logic [31:0] ins;
        logic [31:0] p4;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        ihit = 1'b0; redirect = 1'b0; halt = 1'b0; deq_ready = 1'b0;
        nRST = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_instr", deq_instr, 32'd0);
        chk("rst_pc4", deq_pc4, 32'd0);
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_ren", 32'(imemREN), 32'd1);
        #2;
        nRST = 1'b1;
        mq.delete();
        m_pc   = 32'h0;
        m_halt = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // One cycle against the reference model: drive, compare, clock, update model.
    task automatic cyc(input logic ih, input logic [31:0] ld, input logic dr,
                       input logic rd, input logic [31:0] rp, input logic hl);
        logic        ren, enq, ev, byp;
        logic [31:0] ei, ep;
        ihit = ih; imemload = ld; deq_ready = dr; redirect = rd; redirect_pc = rp; halt = hl;
        #1;
        ren = !m_halt && !rd && (mq.size() < 4);
        enq = ren && ih;
        ev  = (mq.size() != 0);
        ei  = ev ? mq[0].instr : 32'h0;
        ep  = ev ? mq[0].pc4   : 32'h0;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (mq.size() == 0 && enq) begin
            ev = 1'b1; ei = ld; ep = m_pc + 32'd4; byp = dr;
        end
`endif
        chk("ren", 32'(imemREN), 32'(ren));
        chk("addr", imemaddr, m_pc);
        chk("count", 32'(count), 32'(mq.size()));
        chk("valid", 32'(deq_valid), 32'(ev));
        if (ev) begin
            chk("instr", deq_instr, ei);
            chk("pc4", deq_pc4, ep);
        end
        @(posedge CLK);
        if (rd) begin
            mq.delete();
            m_pc = rp;
        end else begin
            if (mq.size() != 0 && dr) void'(mq.pop_front());
            if (enq && !byp) mq.push_back({ld, m_pc + 32'd4});
            if (enq) m_pc = m_pc + 32'd4;
        end
        m_halt = m_halt | hl;
        #1;
    endtask

    initial begin
        //        rst   ih    load          dr    addr   ren   cnt   v     instr         pc4
        vt[0]  = '{1'b0, 1'b1, 32'h20010001, 1'b1, 32'h00, 1'b1, 3'd0, 1'b0, 32'h0,        32'h0};
        vt[1]  = '{1'b0, 1'b1, 32'h20020002, 1'b1, 32'h04, 1'b1, 3'd1, 1'b1, 32'h20010001, 32'h4};
        vt[2]  = '{1'b0, 1'b1, 32'h20030003, 1'b1, 32'h08, 1'b1, 3'd1, 1'b1, 32'h20020002, 32'h8};
        vt[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0C, 1'b1, 3'd1, 1'b1, 32'h20030003, 32'hC};
        vt[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0C, 1'b1, 3'd0, 1'b0, 32'h0,        32'h0};
        vt[5]  = '{1'b1, 1'b1, 32'hA1A1A1A1, 1'b0, 32'h00, 1'b1, 3'd0, 1'b0, 32'h0,        32'h0};
        vt[6]  = '{1'b0, 1'b1, 32'hA2A2A2A2, 1'b0, 32'h04, 1'b1, 3'd1, 1'b1, 32'hA1A1A1A1, 32'h4};
        vt[7]  = '{1'b0, 1'b1, 32'hA3A3A3A3, 1'b0, 32'h08, 1'b1, 3'd2, 1'b1, 32'hA1A1A1A1, 32'h4};
        vt[8]  = '{1'b0, 1'b1, 32'hA4A4A4A4, 1'b0, 32'h0C, 1'b1, 3'd3, 1'b1, 32'hA1A1A1A1, 32'h4};
        vt[9]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h10, 1'b0, 3'd4, 1'b1, 32'hA1A1A1A1, 32'h4};
        vt[10] = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h10, 1'b0, 3'd4, 1'b1, 32'hA1A1A1A1, 32'h4};
        vt[11] = '{1'b0, 1'b1, 32'hA6A6A6A6, 1'b0, 32'h10, 1'b1, 3'd3, 1'b1, 32'hA2A2A2A2, 32'h8};
        vt[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h14, 1'b0, 3'd4, 1'b1, 32'hA2A2A2A2, 32'h8};

        @(posedge CLK);
        #1;
        do_reset();

`ifndef FETCH_QUEUE_BYPASS_EN
        for (int i = 0; i < 13; i++) begin
            if (vt[i].rst) do_reset();
            ihit = vt[i].ih; imemload = vt[i].ld; deq_ready = vt[i].dr;
            redirect = 1'b0; halt = 1'b0;
            #1;
            chk($sformatf("v%0d_addr", i), imemaddr, vt[i].addr);
            chk($sformatf("v%0d_ren", i), 32'(imemREN), 32'(vt[i].ren));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
            chk($sformatf("v%0d_valid", i), 32'(deq_valid), 32'(vt[i].v));
            chk($sformatf("v%0d_instr", i), deq_instr, vt[i].ins);
            chk($sformatf("v%0d_pc4", i), deq_pc4, vt[i].p4);
            @(posedge CLK);
            #1;
        end
`endif

        // redirect with concurrent hit and dequeue on a two-entry FIFO
        do_reset();
        cyc(1'b1, 32'h11110000, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h22220000, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h33330000, 1'b1, 1'b1, 32'h40, 1'b0);
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_addr", imemaddr, 32'h40);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // halt with three entries queued, drain, then redirect while halted
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h44440000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h55550000, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0);
        chk("halt_redir_addr", imemaddr, 32'h80);
        chk("halt_redir_ren", 32'(imemREN), 32'd0);
        cyc(1'b1, 32'h66660000, 1'b1, 1'b0, 32'h0, 1'b0);

        // PC wrap-around
        do_reset();
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b0);
        cyc(1'b1, 32'h77770000, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h77770001, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h77770002, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);

`ifdef FETCH_QUEUE_BYPASS_EN
        do_reset();
        cyc(1'b1, 32'h8C030000, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("byp_count", 32'(count), 32'd0);
        cyc(1'b1, 32'h8C040000, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
`endif

        // mid-stream reset with count=2 and PC=0x1C
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h99990000 + 32'(i), 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h99990006, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_addr", imemaddr, 32'h1C);
        do_reset();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        ih, dr, rd, hl;
            logic [31:0] rp;
            if (i % 50 == 49) do_reset();
            ih = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 19) == 0);
            hl = ($urandom_range(0, 149) == 0);
            rp = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF4 : ($urandom & 32'hFFFFFFFC);
            cyc(ih, $urandom, dr, rd, rp, hl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
